multi_cycle_mips: RTL and testbench

MULTI_CYCLE_MIPS -- requirements
Module: multi_cycle_mips

---
 rtl/mips_pkg.sv | 91 +++++++++
 rtl/mips_alu.sv | 30 +++
 rtl/multi_cycle_mips.sv | 168 ++++++++++++++++
 tb/tb_multi_cycle_mips.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core.
// Contents: opcode/funct constants, 4-bit ALU operation codes, FSM state
// encoding, instruction class encoding and the instruction decode helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
    ALU_OR, ALU_NOR, ALU_XOR, ALU_LUI
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RALU = 4'd0, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t cls;
    alu_op_t op;
    logic    zext;   // immediate is zero-extended (logical immediates, lui)
  } dec_t;

  // Pure function of the instruction word; lw/sw keep the default ADD.
  function automatic dec_t decode_ir(input logic [31:0] ir);
    dec_t d;
    d.cls  = C_ILL;
    d.op   = ALU_ADD;
    d.zext = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        d.cls = C_RALU;
        case (ir[5:0])
          FN_ADD, FN_ADDU: d.op = ALU_ADD;
          FN_SUB, FN_SUBU: d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_XOR:  d.op = ALU_XOR;
          FN_NOR:  d.op = ALU_NOR;
          FN_SLT:  d.op = ALU_SLT;
          FN_SLTU: d.op = ALU_SLTU;
          default: d.cls = C_ILL;
        endcase
      end
      OP_J:              d.cls = C_J;
      OP_JAL:            d.cls = C_JAL;
      OP_BEQ:            begin d.cls = C_BEQ; d.op = ALU_SUB; end
      OP_BNE:            begin d.cls = C_BNE; d.op = ALU_SUB; end
      OP_ADDI, OP_ADDIU: d.cls = C_IALU;
      OP_SLTI:           begin d.cls = C_IALU; d.op = ALU_SLT; end
      OP_SLTIU:          begin d.cls = C_IALU; d.op = ALU_SLTU; end
      OP_ANDI:           begin d.cls = C_IALU; d.op = ALU_AND; d.zext = 1'b1; end
      OP_ORI:            begin d.cls = C_IALU; d.op = ALU_OR;  d.zext = 1'b1; end
      OP_XORI:           begin d.cls = C_IALU; d.op = ALU_XOR; d.zext = 1'b1; end
      OP_LUI:            begin d.cls = C_IALU; d.op = ALU_LUI; d.zext = 1'b1; end
      OP_LW:             d.cls = C_LW;
      OP_SW:             d.cls = C_SW;
      default:           d.cls = C_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU for the multi-cycle MIPS core.
// Ports: op (alu_op_t), a, b (operands) -> y (result), zero (y == 0).
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_NOR:  y = ~(a | b);
      ALU_XOR:  y = a ^ b;
      ALU_LUI:  y = {b[15:0], 16'd0};
      default:  y = '0;
    endcase
    zero = (y == 32'd0);
  end

endmodule

// File: rtl/multi_cycle_mips.sv
// Unified-memory multi-cycle MIPS core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Ports: clk, reset (async, active high); memory master mem_req, mem_we,
// mem_addr, mem_wdata, mem_ready, mem_rdata; status halted, retire; state
// exposes the FSM state for observation.
// Memory handshake: mem_req is the valid; a transfer completes on the rising
// edge where mem_req and mem_ready are both 1. While mem_req=1 and
// mem_ready=0, mem_addr/mem_we/mem_wdata are held because they derive only
// from registers that do not change until completion.
module multi_cycle_mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MEM_AW          = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              halted,
  output logic              retire,
  output state_t            state
);

  logic [31:0] pc, ir, a_q, b_q, alu_out, mdr;
  logic [31:0] rf [32];
  dec_t        dec;
  logic [31:0] sign_imm, zero_imm, alu_b, alu_y;
  logic        alu_zero;
  logic [31:0] pc_branch, pc_jump, rs_val, rt_val;
  logic [29:0] word_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign dec      = decode_ir(ir);
  assign sign_imm = {{16{ir[15]}}, ir[15:0]};
  assign zero_imm = {16'd0, ir[15:0]};
  assign alu_b    = (dec.cls == C_RALU || dec.cls == C_BEQ || dec.cls == C_BNE) ? b_q :
                    (dec.zext ? zero_imm : sign_imm);
  // pc already points at the next instruction when these are used.
  assign pc_branch = pc + {sign_imm[29:0], 2'b00};
  assign pc_jump   = {pc[31:28], ir[25:0], 2'b00};

  assign rs_val = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
  assign rt_val = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];

  mips_alu u_alu (
    .op   (dec.op),
    .a    (a_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Low address bits are dropped so every access is word aligned.
  assign word_addr = (state == MEM) ? alu_out[31:2] : pc[31:2];
  assign mem_addr  = {word_addr[MEM_AW-3:0], 2'b00};
  // Gated by reset so a request is dropped the instant reset asserts and
  // reappears in the first cycle after it releases.
  assign mem_req   = !reset && (state == FETCH || state == MEM);
  assign mem_we    = (state == MEM) && (dec.cls == C_SW);
  assign mem_wdata = b_q;

  // Single register-file write port shared by jal (EXEC) and WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ir[20:16];
    rf_wdata = alu_out;
    if (state == EXEC && dec.cls == C_JAL) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc;
    end else if (state == WB) begin
      rf_we = 1'b1;
      if (dec.cls == C_RALU) rf_waddr = ir[15:11];
      if (dec.cls == C_LW)   rf_wdata = mdr;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      halted  <= 1'b0;
      retire  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q <= rs_val;
          b_q <= rt_val;
          if (dec.cls == C_ILL) begin
            if (TRAP_ON_ILLEGAL) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              retire <= 1'b1;
              state  <= FETCH;
            end
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          alu_out <= alu_y;
          case (dec.cls)
            C_LW, C_SW: state <= MEM;
            C_BEQ: begin
              if (alu_zero) pc <= pc_branch;
              retire <= 1'b1;
              state  <= FETCH;
            end
            C_BNE: begin
              if (!alu_zero) pc <= pc_branch;
              retire <= 1'b1;
              state  <= FETCH;
            end
            C_J, C_JAL: begin
              pc     <= pc_jump;
              retire <= 1'b1;
              state  <= FETCH;
            end
            default: state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (dec.cls == C_SW) begin
              retire <= 1'b1;
              state  <= FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          retire <= 1'b1;
          state  <= FETCH;
        end
        HALT:    halted <= 1'b1;
        default: state  <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Self-checking bench for multi_cycle_mips: one trapping core running a
// directed program from RESET_PC=0x100, and one non-trapping core that must
// step over an illegal opcode.
module tb_multi_cycle_mips;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT (trapping) ----------------
  logic        mem_req, mem_we, mem_ready, halted, retire;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dut_state;

  multi_cycle_mips #(.RESET_PC(32'h100), .MEM_AW(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .halted(halted), .retire(retire), .state(dut_state)
  );

  // ---------------- DUT (non-trapping) ----------------
  logic        nt_req, nt_we, nt_ready, nt_halted, nt_retire;
  logic [31:0] nt_addr, nt_wdata, nt_rdata;
  state_t      nt_state;

  multi_cycle_mips #(.RESET_PC(32'h0), .MEM_AW(32), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .mem_req(nt_req), .mem_we(nt_we),
    .mem_addr(nt_addr), .mem_wdata(nt_wdata), .mem_ready(nt_ready),
    .mem_rdata(nt_rdata), .halted(nt_halted), .retire(nt_retire), .state(nt_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];       // expected fetch addresses, in order
  logic [31:0] fetch_q[$];     // observed fetch addresses
  logic [31:0] exp_lat_q[$];   // expected cycles between retire pulses
  logic [63:0] exp_wr_q[$];    // expected {addr, data} store transfers
  int          ret_q[$];       // cycle numbers of retire pulses

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [512];
  logic        slow_all = 1'b1;   // every access waits 3 cycles
  int          wait_cnt = 0;
  logic [31:0] held_addr = '0;

  initial begin
    int need;
    logic [63:0] e;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (slow_all) need = 3;
        else if (dut_state == MEM || mem_addr == 32'h110 || mem_addr == 32'h114) need = 2;
        else need = 0;
        if (wait_cnt == 0) held_addr = mem_addr;
        else chk("addr_stable", mem_addr, held_addr);
        if (wait_cnt >= need) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[10:2]];
          if (mem_we) begin
            mem[mem_addr[10:2]] = mem_wdata;
            if (exp_wr_q.size() == 0) chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
            else begin
              e = exp_wr_q.pop_front();
              chk("wr_addr", mem_addr, e[63:32]);
              chk("wr_data", mem_wdata, e[31:0]);
            end
          end else if (dut_state == FETCH) begin
            fetch_q.push_back(mem_addr);
          end
          wait_cnt = 0;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Non-trapping core: illegal at 0, addi $6,$0,7 at 4, then spin on j 0x8.
  initial begin
    nt_ready = 1'b1;
    nt_rdata = '0;
    forever begin
      @(negedge clk);
      case (nt_addr)
        32'h0:   nt_rdata = 32'hFC00_0000;
        32'h4:   nt_rdata = 32'h2006_0007;
        default: nt_rdata = 32'h0800_0002;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (retire) ret_q.push_back(cyc);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] e;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'h2001_FFFF;  // addi  $1,$0,-1
    mem[32'h104 >> 2] = 32'h2C22_0001;  // sltiu $2,$1,1
    mem[32'h108 >> 2] = 32'h3023_FFFF;  // andi  $3,$1,0xFFFF
    mem[32'h10C >> 2] = 32'h3C04_1234;  // lui   $4,0x1234
    mem[32'h110 >> 2] = 32'hAC01_0008;  // sw    $1,8($0)
    mem[32'h114 >> 2] = 32'h8C05_0008;  // lw    $5,8($0)
    mem[32'h118 >> 2] = 32'h0800_0000;  // j     0x0
    mem[32'h000 >> 2] = 32'h1000_0002;  // beq   $0,$0,+2
    mem[32'h00C >> 2] = 32'h1400_0002;  // bne   $0,$0,+2
    mem[32'h010 >> 2] = 32'h0800_0010;  // j     0x40
    mem[32'h040 >> 2] = 32'h0C00_0100;  // jal   0x400
    mem[32'h400 >> 2] = 32'h2000_0005;  // addi  $0,$0,5
    mem[32'h404 >> 2] = 32'hAC00_000C;  // sw    $0,12($0)
    mem[32'h408 >> 2] = 32'hFC00_0000;  // illegal

    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
              32'h000, 32'h00C, 32'h010, 32'h040, 32'h400, 32'h404, 32'h408};
    exp_lat_q = '{4, 4, 4, 8, 9, 3, 3, 3, 3, 3, 4, 6};
    exp_wr_q.push_back({32'h8, 32'hFFFF_FFFF});
    exp_wr_q.push_back({32'hC, 32'h0});

    // Reset state and first fetch.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",  {31'd0, mem_we}, 32'd0);
    chk("rst_halted",  {31'd0, halted}, 32'd0);
    chk("rst_retire",  {31'd0, retire}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_req",  {31'd0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h100);
    chk("first_we",   {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #2;
    chk("wait_req",  {31'd0, mem_req}, 32'd1);
    chk("wait_addr", mem_addr, 32'h100);
    // Reset pulse while the fetch is still waiting.
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    slow_all = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rerun_req",  {31'd0, mem_req}, 32'd1);
    chk("rerun_addr", mem_addr, 32'h100);

    // Run the program until the core halts (bounded).
    for (int i = 0; i < 400 && !halted; i++) @(posedge clk);
    #2;
    chk("halt_reached", {31'd0, halted}, 32'd1);
    chk("halt_state", {29'd0, dut_state}, {29'd0, HALT});
    chk("halt_pc", dut.pc, 32'h40C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      chk("halt_req",    {31'd0, mem_req}, 32'd0);
      chk("halt_retire", {31'd0, retire}, 32'd0);
      chk("halt_stays",  {31'd0, halted}, 32'd1);
    end

    // Fetch-order scoreboard.
    chk("fetch_count", fetch_q.size(), exp_q.size());
    while (exp_q.size() > 0 && fetch_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fetch_addr", fetch_q.pop_front(), e);
    end

    // Retire-spacing scoreboard.
    chk("retire_count", ret_q.size(), 13);
    for (int i = 1; i < ret_q.size() && exp_lat_q.size() > 0; i++) begin
      e = exp_lat_q.pop_front();
      chk("latency", ret_q[i] - ret_q[i-1], e);
    end

    chk("writes_left", exp_wr_q.size(), 0);
    chk("r1",  dut.rf[1],  32'hFFFF_FFFF);
    chk("r2",  dut.rf[2],  32'h0000_0000);
    chk("r3",  dut.rf[3],  32'h0000_FFFF);
    chk("r4",  dut.rf[4],  32'h1234_0000);
    chk("r5",  dut.rf[5],  32'hFFFF_FFFF);
    chk("r31", dut.rf[31], 32'h0000_0044);

    // Non-trapping core stepped over the illegal word.
    chk("nt_halted", {31'd0, nt_halted}, 32'd0);
    chk("nt_r6", dut_nt.rf[6], 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
